// File: rtl/resolvedor_tiro_if.sv
// resolvedor_tiro_if
// Bundles the shot-resolver signals that are not clock or reset.
//   shot request   : start, x_tiro, y_tiro, jogador
//   memory port    : read_addr -> vetor_leitura (one-cycle read latency),
//                    write_addr, vetor, wrep1 (player-1), wrep2 (player-2)
//   status/result  : busy, ready, acerto, repetido, afundou, fim_jogo,
//                    tipo_atingido
// master = requester plus memory side, slave = the resolver.
interface resolvedor_tiro_if;
  logic        start;
  logic [3:0]  x_tiro;
  logic [3:0]  y_tiro;
  logic        jogador;
  logic [63:0] vetor_leitura;
  logic [4:0]  read_addr;
  logic [4:0]  write_addr;
  logic [63:0] vetor;
  logic        wrep1;
  logic        wrep2;
  logic        busy;
  logic        ready;
  logic        acerto;
  logic        repetido;
  logic        afundou;
  logic        fim_jogo;
  logic [2:0]  tipo_atingido;

  modport master (
    output start, x_tiro, y_tiro, jogador, vetor_leitura,
    input  read_addr, write_addr, vetor, wrep1, wrep2, busy, ready,
           acerto, repetido, afundou, fim_jogo, tipo_atingido
  );

  modport slave (
    input  start, x_tiro, y_tiro, jogador, vetor_leitura,
    output read_addr, write_addr, vetor, wrep1, wrep2, busy, ready,
           acerto, repetido, afundou, fim_jogo, tipo_atingido
  );
endinterface

// File: rtl/resolvedor_tiro.sv
// resolvedor_tiro
// Resolves one shot against the target player's ship memory. Every record is
// read and compared in turn; the first unhit matching cell is marked and written
// back with the remaining-piece count decremented.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    resolvedor_tiro_if.slave (shot request, memory port, results)
// Record layout: [2:0] tipo, cell i x at [6+8i:3+8i] and y at [10+8i:7+8i],
// [46:43] remaining count, [51:47] hit mask, [63:52] passed through unchanged.
//
// state | meaning
// IDLE  | waiting for start; results of the last shot are held
// READ  | read_addr = k, memory returns the record on the next cycle
// CMP   | compare record k with the latched shot
// WRITE | write the updated record back to slot k
// DONE  | ready pulse, results valid
module resolvedor_tiro #(
  parameter int N_NAVIOS = 11
) (
  input logic             clk,
  input logic             rst_n,
  resolvedor_tiro_if.slave bus
);

  localparam logic [4:0] K_LAST = 5'(N_NAVIOS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CMP   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [4:0]  k;
  logic [3:0]  x_q;
  logic [3:0]  y_q;
  logic        jog_q;
  logic        matched_q;
  logic [8:0]  sum_q;
  logic [4:0]  waddr_q;
  logic [63:0] vetor_q;
  logic        acerto_q;
  logic        repetido_q;
  logic        afundou_q;
  logic        fim_q;
  logic [2:0]  tipo_q;

  // record decode and compare
  logic [2:0]  rec_tipo;
  logic [3:0]  rec_cnt;
  logic [4:0]  rec_mask;
  logic [2:0]  n_valid;
  logic [4:0]  cell_match;
  logic [4:0]  fresh;
  logic        hit;
  logic        repeat_hit;
  logic [2:0]  hit_idx;
  logic [3:0]  cnt_post;
  logic [8:0]  sum_next;
  logic [63:0] rec_upd;

  always_comb begin
    rec_tipo   = bus.vetor_leitura[2:0];
    rec_cnt    = bus.vetor_leitura[46:43];
    rec_mask   = bus.vetor_leitura[51:47];
    n_valid    = (rec_tipo <= 3'd4) ? (3'd5 - rec_tipo) : 3'd0;
    cell_match = '0;
    for (int i = 0; i < 5; i++) begin
      cell_match[i] = (3'(i) < n_valid) &&
                      (bus.vetor_leitura[3 + 8*i +: 4] == x_q) &&
                      (bus.vetor_leitura[7 + 8*i +: 4] == y_q);
    end
    fresh = cell_match & ~rec_mask;

    // Once any record has matched (hit or repeat), later records are only
    // summed, never marked: a single shot can hit at most one cell.
    hit        = (rec_cnt != 4'd0) && !matched_q && (fresh != 5'd0);
    repeat_hit = (rec_cnt != 4'd0) && !matched_q && (cell_match != 5'd0) &&
                 (fresh == 5'd0);

    hit_idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (fresh[i]) hit_idx = 3'(i);
    end

    cnt_post = hit ? (rec_cnt - 4'd1) : rec_cnt;
    sum_next = sum_q + 9'(cnt_post);

    rec_upd                = bus.vetor_leitura;
    rec_upd[47 + hit_idx]  = 1'b1;
    rec_upd[46:43]         = (rec_cnt == 4'd0) ? 4'd0 : (rec_cnt - 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = READ;
      READ:    state_next = CMP;
      CMP: begin
        if (hit)              state_next = WRITE;
        else if (k == K_LAST) state_next = DONE;
        else                  state_next = READ;
      end
      WRITE:   state_next = (k == K_LAST) ? DONE : READ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k          <= '0;
      x_q        <= '0;
      y_q        <= '0;
      jog_q      <= 1'b0;
      matched_q  <= 1'b0;
      sum_q      <= '0;
      waddr_q    <= '0;
      vetor_q    <= '0;
      acerto_q   <= 1'b0;
      repetido_q <= 1'b0;
      afundou_q  <= 1'b0;
      fim_q      <= 1'b0;
      tipo_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            k          <= '0;
            x_q        <= bus.x_tiro;
            y_q        <= bus.y_tiro;
            jog_q      <= bus.jogador;
            matched_q  <= 1'b0;
            sum_q      <= '0;
            acerto_q   <= 1'b0;
            repetido_q <= 1'b0;
            afundou_q  <= 1'b0;
            fim_q      <= 1'b0;
            tipo_q     <= '0;
          end
        end
        CMP: begin
          sum_q <= sum_next;
          if (hit) begin
            matched_q <= 1'b1;
            acerto_q  <= 1'b1;
            tipo_q    <= rec_tipo;
            afundou_q <= (cnt_post == 4'd0);
            waddr_q   <= k;
            vetor_q   <= rec_upd;
          end else if (repeat_hit) begin
            matched_q  <= 1'b1;
            repetido_q <= 1'b1;
          end
          // sum_next already holds the post-update count of this record,
          // so the end-of-game flag is final even if a WRITE follows.
          if (k == K_LAST) fim_q <= (sum_next == 9'd0);
          if (!hit && (k != K_LAST)) k <= k + 5'd1;
        end
        WRITE: begin
          if (k != K_LAST) k <= k + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.read_addr     = k;
  assign bus.write_addr    = waddr_q;
  assign bus.vetor         = vetor_q;
  assign bus.wrep1         = (state == WRITE) &&  jog_q;
  assign bus.wrep2         = (state == WRITE) && !jog_q;
  assign bus.busy          = (state != IDLE);
  assign bus.ready         = (state == DONE);
  assign bus.acerto        = acerto_q;
  assign bus.repetido      = repetido_q;
  assign bus.afundou       = afundou_q;
  assign bus.fim_jogo      = fim_q;
  assign bus.tipo_atingido = tipo_q;

endmodule

// File: tb/tb_resolvedor_tiro.sv
// tb_resolvedor_tiro
// Random and directed shots against two ship memories kept in the bench.
// A reference model computes each shot's outcome from the record rules and
// queues it; a monitor pops and compares on every ready pulse.
module tb_resolvedor_tiro;
  localparam int N = 11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  resolvedor_tiro_if bus ();

  resolvedor_tiro #(.N_NAVIOS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        acerto;
    logic        repetido;
    logic        afundou;
    logic        fim;
    logic [2:0]  tipo;
    logic [7:0]  lat;
    logic        wr;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        wjog;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  logic [63:0] mem1[N];
  logic [63:0] mem2[N];
  logic [63:0] ref1[N];
  logic [63:0] ref2[N];
  logic        load = 1'b0;
  logic        cur_jog = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // memory: synchronous read, one-cycle latency; jogador=0 targets player 2
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) begin
        mem1[i] <= ref1[i];
        mem2[i] <= ref2[i];
      end
    end else begin
      if (bus.wrep1) mem1[bus.write_addr] <= bus.vetor;
      if (bus.wrep2) mem2[bus.write_addr] <= bus.vetor;
    end
    bus.vetor_leitura <= cur_jog ? mem1[bus.read_addr] : mem2[bus.read_addr];
  end

  function automatic logic [63:0] mkrec(input logic [2:0] t, input logic [3:0] cnt,
                                        input logic [3:0] x0, input logic [3:0] y0,
                                        input logic [3:0] x1, input logic [3:0] y1);
    logic [63:0] r;
    r = '0;
    r[2:0]   = t;
    r[6:3]   = x0;
    r[10:7]  = y0;
    r[14:11] = x1;
    r[18:15] = y1;
    r[46:43] = cnt;
    return r;
  endfunction

  // reference: scan all records; first unhit matching valid cell of a live
  // record is hit, a matching already-hit cell is a repeat; either ends matching
  function automatic exp_t model(input logic [3:0] x, input logic [3:0] y, input logic jog);
    exp_t e;
    logic [63:0] rec;
    int t, n, cnt, hidx, sum;
    bit rep, matched;
    e = '0;
    e.lat = 8'(2 * N + 1);
    matched = 0;
    sum = 0;
    for (int r = 0; r < N; r++) begin
      rec  = jog ? ref1[r] : ref2[r];
      t    = int'(rec[2:0]);
      n    = (t <= 4) ? 5 - t : 0;
      cnt  = int'(rec[46:43]);
      hidx = -1;
      rep  = 0;
      if (cnt > 0 && !matched) begin
        for (int i = 0; i < n; i++) begin
          if (rec[3 + 8*i +: 4] == x && rec[7 + 8*i +: 4] == y) begin
            if (!rec[47 + i]) begin
              if (hidx < 0) hidx = i;
            end else rep = 1;
          end
        end
      end
      if (hidx >= 0) begin
        matched = 1;
        cnt = cnt - 1;
        rec[47 + hidx] = 1'b1;
        rec[46:43] = 4'(cnt);
        e.acerto  = 1'b1;
        e.tipo    = 3'(t);
        e.afundou = (cnt == 0);
        e.wr      = 1'b1;
        e.waddr   = 5'(r);
        e.wdata   = rec;
        e.wjog    = jog;
        e.lat     = e.lat + 8'd1;
        if (jog) ref1[r] = rec;
        else     ref2[r] = rec;
      end else if (rep) begin
        matched = 1;
        e.repetido = 1'b1;
      end
      sum += cnt;
    end
    e.fim = (sum == 0);
    return e;
  endfunction

  // monitor / scoreboard
  initial begin
    int cyc, nwr;
    bit run;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        wj;
    exp_t e;
    cyc = 0; nwr = 0; run = 0; wa = '0; wd = '0; wj = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
        run = 0;
      end else begin
        if (bus.wrep1 && bus.wrep2) chk("wrep_exclusive", {63'd0, bus.wrep1 & bus.wrep2}, 64'd0);
        if (!run) begin
          if (bus.busy) begin
            run = 1; cyc = 1; nwr = 0;
          end
        end else cyc++;
        if (bus.wrep1 || bus.wrep2) begin
          nwr++;
          wa = bus.write_addr;
          wd = bus.vetor;
          wj = bus.wrep1;
        end
        if (bus.ready) begin
          if (q.size() == 0) begin
            chk("ready_without_shot", 64'(q.size() + 1), 64'd0);
          end else begin
            e = q.pop_front();
            chk("latency", 64'(cyc), 64'(e.lat));
            chk("acerto", {63'd0, bus.acerto}, {63'd0, e.acerto});
            chk("repetido", {63'd0, bus.repetido}, {63'd0, e.repetido});
            chk("afundou", {63'd0, bus.afundou}, {63'd0, e.afundou});
            chk("fim_jogo", {63'd0, bus.fim_jogo}, {63'd0, e.fim});
            chk("tipo_atingido", {61'd0, bus.tipo_atingido}, {61'd0, e.tipo});
            chk("write_count", 64'(nwr), e.wr ? 64'd1 : 64'd0);
            if (e.wr && nwr > 0) begin
              chk("write_addr", {59'd0, wa}, {59'd0, e.waddr});
              chk("write_data", wd, e.wdata);
              chk("write_side", {63'd0, wj}, {63'd0, e.wjog});
            end
          end
          run = 0;
        end
      end
    end
  end

  task automatic clear_ref();
    for (int i = 0; i < N; i++) begin
      ref1[i] = '0;
      ref2[i] = '0;
    end
  endtask

  task automatic load_mem();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic shot(input logic [3:0] x, input logic [3:0] y, input logic jog, input bit disturb);
    exp_t e;
    int n;
    n = 0;
    while (bus.busy && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    e = model(x, y, jog);
    q.push_back(e);
    bus.x_tiro = x; bus.y_tiro = y; bus.jogador = jog; cur_jog = jog;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (n < 100) begin
      if (disturb && n < 15) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.x_tiro  = 4'($urandom);
        bus.y_tiro  = 4'($urandom);
        bus.jogador = 1'($urandom);
      end else bus.start = 1'b0;
      @(negedge clk);
      n++;
      if (!bus.busy) break;
    end
    bus.start = 1'b0;
    if (bus.busy) chk("timeout_busy", {63'd0, bus.busy}, 64'd0);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_busy"},     {63'd0, bus.busy}, 64'd0);
    chk({pfx, "_ready"},    {63'd0, bus.ready}, 64'd0);
    chk({pfx, "_wrep1"},    {63'd0, bus.wrep1}, 64'd0);
    chk({pfx, "_wrep2"},    {63'd0, bus.wrep2}, 64'd0);
    chk({pfx, "_acerto"},   {63'd0, bus.acerto}, 64'd0);
    chk({pfx, "_repetido"}, {63'd0, bus.repetido}, 64'd0);
    chk({pfx, "_afundou"},  {63'd0, bus.afundou}, 64'd0);
    chk({pfx, "_fim"},      {63'd0, bus.fim_jogo}, 64'd0);
    chk({pfx, "_tipo"},     {61'd0, bus.tipo_atingido}, 64'd0);
    chk({pfx, "_raddr"},    {59'd0, bus.read_addr}, 64'd0);
    chk({pfx, "_waddr"},    {59'd0, bus.write_addr}, 64'd0);
    chk({pfx, "_vetor"},    bus.vetor, 64'd0);
  endtask

  initial begin
    logic [63:0] r;
    int n;
    bus.start = 1'b0; bus.x_tiro = '0; bus.y_tiro = '0; bus.jogador = 1'b0;
    clear_ref();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    check_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    mon_en = 1'b1;

    // miss, hit, repeat on a tipo-3 ship with two cells
    clear_ref();
    r = mkrec(3'd3, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3);
    r[63:52] = 12'hA5C;
    ref2[4] = r;
    ref1[7] = r;
    load_mem();
    shot(4'd7, 4'd7, 1'b0, 1'b0);
    shot(4'd3, 4'd3, 1'b0, 1'b0);
    shot(4'd3, 4'd3, 1'b0, 1'b0);
    shot(4'd2, 4'd3, 1'b1, 1'b1);

    // sink of the only ship ends the game
    clear_ref();
    ref2[6] = mkrec(3'd4, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0);
    load_mem();
    shot(4'd0, 4'd0, 1'b0, 1'b0);

    // zero-valued unused cells of a tipo-4 ship are never compared
    clear_ref();
    ref2[2] = mkrec(3'd4, 4'd1, 4'd5, 4'd5, 4'd0, 4'd0);
    load_mem();
    shot(4'd0, 4'd0, 1'b0, 1'b0);

    // all-empty memory
    clear_ref();
    load_mem();
    shot(4'd9, 4'd9, 1'b1, 1'b0);

    // random memories and shots, inputs disturbed while busy
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < N; i++) begin
        for (int p = 0; p < 2; p++) begin
          r = {$urandom, $urandom};
          r[2:0] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
          for (int c = 0; c < 5; c++) begin
            r[3 + 8*c +: 4] = 4'($urandom_range(0, 3));
            r[7 + 8*c +: 4] = 4'($urandom_range(0, 3));
          end
          r[46:43] = 4'($urandom_range(0, 5));
          if (p == 0) ref1[i] = r;
          else        ref2[i] = r;
        end
      end
      load_mem();
      for (int s = 0; s < 6; s++)
        shot(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom), 1'b1);
    end

    // reset during WRITE
    mon_en = 1'b0;
    clear_ref();
    ref2[0] = mkrec(3'd4, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0);
    load_mem();
    @(negedge clk);
    bus.x_tiro = 4'd1; bus.y_tiro = 4'd1; bus.jogador = 1'b0; cur_jog = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.wrep2 && n < 60);
    chk("reached_write", {63'd0, bus.wrep2}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("midwrite");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // first start after reset is accepted normally
    clear_ref();
    ref2[0] = mkrec(3'd0, 4'd5, 4'd1, 4'd1, 4'd2, 4'd2);
    ref2[9] = mkrec(3'd2, 4'd3, 4'd2, 4'd2, 4'd4, 4'd4);
    load_mem();
    shot(4'd2, 4'd2, 1'b0, 1'b1);
    shot(4'd4, 4'd4, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
